moving_average_window_ctrl: RTL

- Per-channel controller that configures and sequences the moving-average filter in the pulse-analyzer datapath.
- Accepts a window setting from the register interface and restarts the filter on every accepted write: clear, then fill, then run.
- Gates the filter's sample enable and flags when its output is valid, i.e. only once the full window holds fresh samples.
- The top level instantiates one copy per channel (CHANNEL_SIZE).

---
 rtl/moving_average_window_ctrl_pkg.sv | 34 +++
 rtl/moving_average_window_ctrl_if.sv | 31 +++
 rtl/moving_average_window_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/moving_average_window_ctrl_pkg.sv
// Shared settings for the moving-average window controller: widths, limits,
// controller state encoding and the register write payload layout.
package moving_average_window_ctrl_pkg;

   localparam int unsigned SIZE_REGISTER                   = 16;
   localparam int unsigned SIZE_MOVING_AVERAGE_WINDOW_CODE = 3;
   localparam int unsigned MOVING_AVERAGE_MAX_WINDOW_CODE  = 6;
   localparam int unsigned SIZE_WINDOW_CODE                = SIZE_MOVING_AVERAGE_WINDOW_CODE;
   localparam int unsigned MAX_WINDOW_CODE                 = MOVING_AVERAGE_MAX_WINDOW_CODE;
   localparam int unsigned SIZE_FILL_COUNTER               = 7;
   localparam int unsigned CFG_ENABLE_BIT                  = 15;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      FILL,
      RUN
   } ma_ctrl_state_t;

   // Register write word: enable in the MSB, window code in the low bits.
   typedef struct packed {
      logic                                           enable;
      logic [SIZE_REGISTER-SIZE_WINDOW_CODE-2:0]      reserved;
      logic [SIZE_WINDOW_CODE-1:0]                    code;
   } cfg_word_t;

   // Window length for a (legal) log2 window code.
   function automatic logic [SIZE_FILL_COUNTER-1:0] window_of(
      input logic [SIZE_WINDOW_CODE-1:0] code
   );
      return SIZE_FILL_COUNTER'(1) << code;
   endfunction

endpackage

// File: rtl/moving_average_window_ctrl_if.sv
// Register/sample inputs and filter control outputs of one channel's
// moving-average window controller.
//   master: register interface + ADC strobe side (drives cfg_*, sample_valid)
//   slave : the controller (drives the ma_*, busy and cfg_error outputs)
interface moving_average_window_ctrl_if;
   import moving_average_window_ctrl_pkg::*;

   logic                         cfg_we;
   logic [SIZE_REGISTER-1:0]     cfg_data;
   logic                         sample_valid;
   logic                         ma_clear;
   logic                         ma_sample_en;
   logic [SIZE_WINDOW_CODE-1:0]  ma_shift;
   logic [SIZE_FILL_COUNTER-1:0] ma_window;
   logic                         ma_result_valid;
   logic                         busy;
   logic                         cfg_error;

   modport master (
      output cfg_we, cfg_data, sample_valid,
      input  ma_clear, ma_sample_en, ma_shift, ma_window,
             ma_result_valid, busy, cfg_error
   );

   modport slave (
      input  cfg_we, cfg_data, sample_valid,
      output ma_clear, ma_sample_en, ma_shift, ma_window,
             ma_result_valid, busy, cfg_error
   );

endinterface

// File: rtl/moving_average_window_ctrl.sv
// Per-channel moving-average window controller. Every accepted register write
// restarts the filter (CLEAR one cycle, FILL until a full window of fresh
// samples, then RUN) and flags when the filter output is a full-window average.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - slave side of moving_average_window_ctrl_if:
//           cfg_we/cfg_data/sample_valid in; ma_clear, ma_sample_en (gated
//           strobe, same cycle as sample_valid), ma_shift, ma_window,
//           ma_result_valid, busy, cfg_error out (registered)
module moving_average_window_ctrl
   import moving_average_window_ctrl_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   moving_average_window_ctrl_if.slave  bus
);

   ma_ctrl_state_t               state;
   ma_ctrl_state_t               state_next;
   logic [SIZE_FILL_COUNTER-1:0] fill_count;
   logic [SIZE_FILL_COUNTER-1:0] fill_count_next;
   logic [SIZE_FILL_COUNTER-1:0] fill_inc;
   logic [SIZE_WINDOW_CODE-1:0]  shift_q;
   logic [SIZE_WINDOW_CODE-1:0]  shift_next;
   logic [SIZE_FILL_COUNTER-1:0] window_q;
   logic [SIZE_FILL_COUNTER-1:0] window_next;
   logic                         clear_q;
   logic                         clear_next;
   logic                         busy_q;
   logic                         busy_next;
   logic                         valid_q;
   logic                         valid_next;
   logic                         error_q;
   logic                         error_next;
   logic                         sample_en_c;
   logic                         sample_ok;
   logic                         code_too_big;
   logic [SIZE_WINDOW_CODE-1:0]  code_sat;
   cfg_word_t                    cfg_word;
   logic                         unused_reserved;

   assign cfg_word        = cfg_word_t'(bus.cfg_data);
   assign unused_reserved = ^cfg_word.reserved;

   // A write in the same cycle steals the sample; reset suppresses it as well.
   assign sample_ok    = bus.sample_valid && !bus.cfg_we && !reset;
   assign fill_inc     = fill_count + SIZE_FILL_COUNTER'(1);
   assign code_too_big = cfg_word.code > SIZE_WINDOW_CODE'(MAX_WINDOW_CODE);
   assign code_sat     = code_too_big ? SIZE_WINDOW_CODE'(MAX_WINDOW_CODE) : cfg_word.code;

   // Next state, counter, applied window and output values.
   always_comb begin
      state_next      = state;
      fill_count_next = fill_count;
      shift_next      = shift_q;
      window_next     = window_q;
      valid_next      = 1'b0;
      error_next      = 1'b0;
      sample_en_c     = 1'b0;

      case (state)
         IDLE: begin
         end
         CLEAR: begin
            fill_count_next = '0;
            state_next      = FILL;
         end
         FILL: begin
            if (sample_ok) begin
               sample_en_c     = 1'b1;
               fill_count_next = fill_inc;
               if (fill_inc == window_q) begin
                  state_next = RUN;
                  valid_next = 1'b1;
               end
            end
         end
         RUN: begin
            if (sample_ok) begin
               sample_en_c = 1'b1;
               valid_next  = 1'b1;
            end
         end
      endcase

      // A write always restarts (or stops) the channel, whatever the state.
      if (bus.cfg_we) begin
         shift_next  = code_sat;
         window_next = window_of(code_sat);
         error_next  = code_too_big;
         state_next  = cfg_word.enable ? CLEAR : IDLE;
      end

      clear_next = (state_next == CLEAR);
      busy_next  = (state_next == CLEAR) || (state_next == FILL);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fill_count <= '0;
         shift_q    <= '0;
         window_q   <= SIZE_FILL_COUNTER'(1);
         clear_q    <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state      <= state_next;
         fill_count <= fill_count_next;
         shift_q    <= shift_next;
         window_q   <= window_next;
         clear_q    <= clear_next;
         busy_q     <= busy_next;
         valid_q    <= valid_next;
         error_q    <= error_next;
      end
   end

   assign bus.ma_clear        = clear_q;
   assign bus.ma_sample_en    = sample_en_c;
   assign bus.ma_shift        = shift_q;
   assign bus.ma_window       = window_q;
   assign bus.ma_result_valid = valid_q;
   assign bus.busy            = busy_q;
   assign bus.cfg_error       = error_q;

endmodule
